acc_cpu_hs: RTL and testbench

//  Parametrised accumulator CPU: fetch/decode/execute control, IR, PC, AC, ALU and flags in one block.

---
 rtl/acc_cpu_hs.sv | 195 +++++++++++++++++++
 tb/tb_acc_cpu_hs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_hs.sv
// Accumulator CPU with fetch/decode/execute control and a req/ack memory port.
// Each instruction is two words: an opcode word (op in [3:0], immediate flag in bit 4)
// followed by an operand word. Memory may stall any access by withholding ack.
module acc_cpu_hs #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ac_o,
  output logic [2:0]        flags_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    StF1  = 3'd0,
    StF2  = 3'd1,
    StMem = 3'd2,
    StEx  = 3'd3,
    StHlt = 3'd4
  } state_e;

  localparam logic [3:0] OpNop = 4'h0, OpLda = 4'h1, OpSta = 4'h2, OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4, OpAnd = 4'h5, OpOr  = 4'h6, OpXor = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8, OpJz  = 4'h9, OpJn  = 4'hA, OpJc  = 4'hB;
  localparam logic [3:0] OpShl = 4'hC, OpShr = 4'hD, OpNot = 4'hE, OpHlt = 4'hF;

  state_e            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [4:0]        ir_q, ir_d;
  logic              c_q, c_d, n_q, n_d, z_q, z_d;

  logic [3:0]        op;
  logic              imm;
  logic              ac_wr;
  logic              mem_operand;
  logic [DATA_W-1:0] val;
  logic [DATA_W:0]   sum, diff;

  assign op  = ir_q[3:0];
  assign imm = ir_q[4];

  // Operand source and ALU adders; the extra top bit is carry out / borrow.
  always_comb begin
    val         = imm ? opr_q : mdr_q;
    sum         = {1'b0, ac_q} + {1'b0, val};
    diff        = {1'b0, ac_q} - {1'b0, val};
    mem_operand = !imm && (op == OpLda || op == OpAdd || op == OpSub ||
                           op == OpAnd || op == OpOr  || op == OpXor);
  end

  // Next-state, datapath updates and memory port drive.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ac_d      = ac_q;
    opr_d     = opr_q;
    mdr_d     = mdr_q;
    ir_d      = ir_q;
    c_d       = c_q;
    n_d       = n_q;
    z_d       = z_q;
    ac_wr     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = ac_q;

    unique case (state_q)
      StF1: begin
        // run_q holds off the first request for one cycle after reset, so an ack
        // belonging to an aborted access can never be taken as a fresh fetch.
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_d    = mem_rdata[4:0];
            pc_d    = pc_q + ADDR_W'(1);
            state_d = StF2;
          end
        end
      end
      StF2: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          opr_d = mem_rdata;
          pc_d  = pc_q + ADDR_W'(1);
          if (op == OpSta || mem_operand) state_d = StMem;
          else if (op == OpHlt)           state_d = StHlt;
          else                            state_d = StEx;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_addr = opr_q[ADDR_W-1:0];
        mem_we   = (op == OpSta);
        if (mem_ack) begin
          if (op == OpSta) begin
            state_d = StF1;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StEx;
          end
        end
      end
      StEx: begin
        state_d = StF1;
        case (op)
          OpLda: begin ac_d = val;        ac_wr = 1'b1; end
          OpAnd: begin ac_d = ac_q & val; ac_wr = 1'b1; end
          OpOr:  begin ac_d = ac_q | val; ac_wr = 1'b1; end
          OpXor: begin ac_d = ac_q ^ val; ac_wr = 1'b1; end
          OpNot: begin ac_d = ~ac_q;      ac_wr = 1'b1; end
          OpAdd: begin
            ac_d  = sum[DATA_W-1:0];
            c_d   = sum[DATA_W];
            ac_wr = 1'b1;
          end
          OpSub: begin
            ac_d  = diff[DATA_W-1:0];
            c_d   = diff[DATA_W];
            ac_wr = 1'b1;
          end
          OpShl: begin
            ac_d  = {ac_q[DATA_W-2:0], 1'b0};
            c_d   = ac_q[DATA_W-1];
            ac_wr = 1'b1;
          end
          OpShr: begin
            ac_d  = {1'b0, ac_q[DATA_W-1:1]};
            c_d   = ac_q[0];
            ac_wr = 1'b1;
          end
          OpJmp: pc_d = opr_q[ADDR_W-1:0];
          OpJz:  if (z_q) pc_d = opr_q[ADDR_W-1:0];
          OpJn:  if (n_q) pc_d = opr_q[ADDR_W-1:0];
          OpJc:  if (c_q) pc_d = opr_q[ADDR_W-1:0];
          default: ;
        endcase
        if (ac_wr) begin
          z_d = (ac_d == '0);
          n_d = ac_d[DATA_W-1];
        end
      end
      StHlt: state_d = StHlt;
      default: state_d = StF1;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StF1;
      run_q   <= 1'b0;
      pc_q    <= ADDR_W'(RESET_PC);
      ac_q    <= '0;
      opr_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      opr_q   <= opr_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign halted  = (state_q == StHlt);
  assign pc_o    = pc_q;
  assign ac_o    = ac_q;
  assign flags_o = {c_q, n_q, z_q};
  assign state_o = state_q;

endmodule

// File: tb/tb_acc_cpu_hs.sv
// Directed bench for acc_cpu_hs: an 8-bit instance behind a stallable memory model
// and a 16/12-bit instance behind a zero-wait memory.
module tb_acc_cpu_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // 8-bit instance signals
  logic       rst8, req8, we8, ack8, halted8;
  logic [7:0] addr8, wdata8, rdata8, pc8, ac8;
  logic [2:0] flags8, state8;

  // 16-bit data / 12-bit address instance signals
  logic        rst16, req16, we16, ack16, halted16;
  logic [11:0] addr16, pc16;
  logic [15:0] wdata16, rdata16, ac16;
  logic [2:0]  flags16, state16;

  acc_cpu_hs #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut8 (
    .clk(clk), .rst(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8), .halted(halted8),
    .pc_o(pc8), .ac_o(ac8), .flags_o(flags8), .state_o(state8)
  );

  acc_cpu_hs #(.DATA_W(16), .ADDR_W(12), .RESET_PC(0)) dut16 (
    .clk(clk), .rst(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ack(ack16), .halted(halted16),
    .pc_o(pc16), .ac_o(ac16), .flags_o(flags16), .state_o(state16)
  );

  // 8-bit memory: tied ack, random 0-5 wait states, or ack forced low.
  logic [7:0]  mem8 [256];
  logic        ld8_en, clr8, tie8, hold8;
  logic [7:0]  ld8_addr, ld8_data;
  int unsigned wcnt8 = 0;

  assign rdata8 = mem8[addr8];
  assign ack8   = hold8 ? 1'b0 : (tie8 ? 1'b1 : (req8 && wcnt8 == 0));

  always @(posedge clk) begin
    if (clr8) for (int i = 0; i < 256; i++) mem8[i] <= 8'h00;
    else if (ld8_en) mem8[ld8_addr] <= ld8_data;
    else if (rst8 && req8 && ack8 && we8) mem8[addr8] <= wdata8;
  end

  always @(posedge clk) begin
    if (req8 && !ack8 && wcnt8 != 0) wcnt8 <= wcnt8 - 1;
    else wcnt8 <= $urandom_range(0, 5);
  end

  // Address/we/wdata must hold while a request waits for ack.
  logic        hv = 1'b0;
  logic        h_we;
  logic [7:0]  h_addr, h_wdata;
  int unsigned stab_err = 0;
  always @(posedge clk) begin
    if (hv && req8 && (addr8 !== h_addr || we8 !== h_we || wdata8 !== h_wdata))
      stab_err <= stab_err + 1;
    hv      <= rst8 && req8 && !ack8;
    h_addr  <= addr8;
    h_we    <= we8;
    h_wdata <= wdata8;
  end

  // 16-bit memory, zero wait.
  logic [15:0] mem16 [4096];
  logic        ld16_en, clr16;
  logic [11:0] ld16_addr;
  logic [15:0] ld16_data;
  assign rdata16 = mem16[addr16];
  assign ack16   = 1'b1;

  always @(posedge clk) begin
    if (clr16) for (int i = 0; i < 4096; i++) mem16[i] <= 16'h0000;
    else if (ld16_en) mem16[ld16_addr] <= ld16_data;
    else if (rst16 && req16 && ack16 && we16) mem16[addr16] <= wdata16;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] d);
    ld8_en = 1'b1; ld8_addr = a; ld8_data = d;
    tick(1);
    ld8_en = 1'b0;
  endtask

  task automatic load16(input logic [11:0] a, input logic [15:0] d);
    ld16_en = 1'b1; ld16_addr = a; ld16_data = d;
    tick(1);
    ld16_en = 1'b0;
  endtask

  task automatic clear8();
    clr8 = 1'b1;
    tick(1);
    clr8 = 1'b0;
  endtask

  // LDA #5; ADD #3; STA 0x20; HLT
  task automatic prog1();
    clear8();
    load8(8'h00, 8'h11); load8(8'h01, 8'h05);
    load8(8'h02, 8'h13); load8(8'h03, 8'h03);
    load8(8'h04, 8'h02); load8(8'h05, 8'h20);
    load8(8'h06, 8'h0F); load8(8'h07, 8'h00);
  endtask

  task automatic wait_halt8(input int max, output int n);
    n = 0;
    while (!halted8 && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst8 = 1'b0; rst16 = 1'b0; tie8 = 1'b1; hold8 = 1'b0;
    ld8_en = 1'b0; clr8 = 1'b0; ld8_addr = '0; ld8_data = '0;
    ld16_en = 1'b0; clr16 = 1'b0; ld16_addr = '0; ld16_data = '0;
    tick(1);
    clr16 = 1'b1; tick(1); clr16 = 1'b0;

    // Reset state
    prog1();
    tick(1);
    check("rst_pc", pc8, 8'h00);
    check("rst_ac", ac8, 8'h00);
    check("rst_flags", flags8, 3'b000);
    check("rst_state", state8, 3'd0);
    check("rst_halted", halted8, 1'b0);
    check("rst_req", req8, 1'b0);
    check("rst_we", we8, 1'b0);
    check("rst_addr", addr8, 8'h00);
    check("rst_wdata", wdata8, 8'h00);
    check("rst16_pc", pc16, 12'h000);
    check("rst16_req", req16, 1'b0);

    // 1: zero-wait program
    rst8 = 1'b1;
    wait_halt8(40, n);
    check("t1_cycles", n, 12);
    check("t1_mem20", mem8[8'h20], 8'h08);
    check("t1_ac", ac8, 8'h08);
    check("t1_flags", flags8, 3'b000);
    check("t1_pc", pc8, 8'h08);
    check("t1_state", state8, 3'd4);
    tick(3);
    check("t1_halt_noreq", req8, 1'b0);
    check("t1_halted", halted8, 1'b1);

    // 2: random wait states, same program
    rst8 = 1'b0;
    prog1();
    tie8 = 1'b0;
    rst8 = 1'b1;
    wait_halt8(500, n);
    check("t2_halted", halted8, 1'b1);
    check("t2_stalled", n > 12, 1'b1);
    check("t2_mem20", mem8[8'h20], 8'h08);
    check("t2_ac", ac8, 8'h08);
    check("t2_flags", flags8, 3'b000);
    check("t2_pc", pc8, 8'h08);
    check("t2_stable", stab_err, 0);

    // 3: carry/zero, JZ taken, borrow/negative
    rst8 = 1'b0; tie8 = 1'b1;
    clear8();
    load8(8'h00, 8'h11); load8(8'h01, 8'hFF);
    load8(8'h02, 8'h13); load8(8'h03, 8'h01);
    load8(8'h04, 8'h09); load8(8'h05, 8'h10);
    load8(8'h10, 8'h14); load8(8'h11, 8'h01);
    load8(8'h12, 8'h0F); load8(8'h13, 8'h00);
    rst8 = 1'b1;
    tick(7);
    check("t3_add_ac", ac8, 8'h00);
    check("t3_add_flags", flags8, 3'b101);
    tick(3);
    check("t3_jz_pc", pc8, 8'h10);
    tick(3);
    check("t3_sub_ac", ac8, 8'hFF);
    check("t3_sub_flags", flags8, 3'b110);
    tick(2);
    check("t3_halted", halted8, 1'b1);
    check("t3_pc", pc8, 8'h14);

    // 4: shifts, PC wrap on operand fetch, memory-operand OR
    rst8 = 1'b0;
    clear8();
    load8(8'h00, 8'h11); load8(8'h01, 8'h81);
    load8(8'h02, 8'h0C); load8(8'h03, 8'h00);
    load8(8'h04, 8'h0D); load8(8'h05, 8'h00);
    load8(8'h06, 8'h08); load8(8'h07, 8'hFD);
    load8(8'hFD, 8'h00); load8(8'hFE, 8'h00);
    load8(8'hFF, 8'h06); load8(8'h11, 8'h40);
    rst8 = 1'b1;
    tick(7);
    check("t4_shl_ac", ac8, 8'h02);
    check("t4_shl_flags", flags8, 3'b100);
    tick(3);
    check("t4_shr_ac", ac8, 8'h01);
    check("t4_shr_flags", flags8, 3'b000);
    tick(3);
    check("t4_jmp_pc", pc8, 8'hFD);
    tick(3);
    check("t4_nop_pc", pc8, 8'hFF);
    tick(2);
    check("t4_wrap_pc", pc8, 8'h01);
    check("t4_mem_state", state8, 3'd2);
    check("t4_mem_addr", addr8, 8'h11);
    tick(2);
    check("t4_or_ac", ac8, 8'h41);
    check("t4_or_flags", flags8, 3'b000);
    check("t4_or_state", state8, 3'd0);

    // 5: reset while STA waits on ack, late ack after release
    rst8 = 1'b0;
    prog1();
    rst8 = 1'b1;
    tick(9);
    check("t5_in_mem", state8, 3'd2);
    check("t5_req", req8, 1'b1);
    check("t5_we", we8, 1'b1);
    check("t5_addr", addr8, 8'h20);
    hold8 = 1'b1;
    tick(2);
    check("t5_stall_state", state8, 3'd2);
    check("t5_no_write", mem8[8'h20], 8'h00);
    rst8 = 1'b0;
    tick(1);
    check("t5_rst_req", req8, 1'b0);
    check("t5_rst_state", state8, 3'd0);
    check("t5_rst_pc", pc8, 8'h00);
    check("t5_rst_ac", ac8, 8'h00);
    check("t5_rst_flags", flags8, 3'b000);
    check("t5_rst_mem", mem8[8'h20], 8'h00);
    rst8 = 1'b1; hold8 = 1'b0;
    tick(1);
    check("t5_late_ack_state", state8, 3'd0);
    check("t5_late_ack_pc", pc8, 8'h00);
    check("t5_refetch_req", req8, 1'b1);
    tick(1);
    check("t5_fetch_state", state8, 3'd1);
    check("t5_fetch_pc", pc8, 8'h01);
    wait_halt8(40, n);
    check("t5_halted", halted8, 1'b1);
    check("t5_mem20", mem8[8'h20], 8'h08);

    // 6: 16-bit data, 12-bit address
    load16(12'h000, 16'h0011); load16(12'h001, 16'h8000);
    load16(12'h002, 16'h0013); load16(12'h003, 16'h8000);
    load16(12'h004, 16'h0008); load16(12'h005, 16'h0FFF);
    load16(12'hFFF, 16'h000F);
    rst16 = 1'b1;
    tick(7);
    check("t6_add_ac", ac16, 16'h0000);
    check("t6_add_flags", flags16, 3'b101);
    tick(3);
    check("t6_jmp_pc", pc16, 12'hFFF);
    tick(2);
    check("t6_halted", halted16, 1'b1);
    check("t6_wrap_pc", pc16, 12'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
